// File: rtl/harvard_fetch_alu.sv
// Harvard-style fetch/execute slice: free-running program counter, read-only
// instruction ROM with combinational read, and a registered 32-bit ALU.
module harvard_fetch_alu #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32,
    // Program image, fixed at elaboration; the default is the bring-up program.
    parameter logic [DATA_W-1:0] PROGRAM [2**ADDR_W] = '{
        0:       32'h00005003,
        1:       32'h10005003,
        2:       32'h2000C00A,
        3:       32'h30F0F0FF,
        4:       32'h40F0000F,
        5:       32'h50FFF0F0,
        6:       32'h10003005,
        7:       32'h7000101F,
        default: 32'h00000000
    }
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] counter,
    output logic [DATA_W-1:0] instruction_out,
    output logic [DATA_W-1:0] out
);

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_MUL  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_NOT  = 4'd6,
        OP_SHL  = 4'd7,
        OP_SHR  = 4'd8,
        OP_PASS = 4'd9,
        OP_SLT  = 4'd10,
        OP_SEQ  = 4'd11
    } opcode_t;

    opcode_t           opcode;
    logic [DATA_W-1:0] operand_a;
    logic [DATA_W-1:0] operand_b;
    logic [4:0]        shift_amount;
    logic [DATA_W-1:0] alu_result;

    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= '0;
        end else begin
            counter <= counter + 1'b1;
        end
    end

    assign instruction_out = PROGRAM[counter];

    // Operands are 12-bit fields zero-extended to the datapath width; bits 27:24 are ignored.
    assign opcode       = opcode_t'(instruction_out[31:28]);
    assign operand_a    = {{(DATA_W-12){1'b0}}, instruction_out[23:12]};
    assign operand_b    = {{(DATA_W-12){1'b0}}, instruction_out[11:0]};
    assign shift_amount = instruction_out[4:0];

    always_comb begin
        alu_result = '0;
        case (opcode)
            OP_ADD:  alu_result = operand_a + operand_b;
            OP_SUB:  alu_result = operand_a - operand_b;
            OP_MUL:  alu_result = operand_a * operand_b;
            OP_AND:  alu_result = operand_a & operand_b;
            OP_OR:   alu_result = operand_a | operand_b;
            OP_XOR:  alu_result = operand_a ^ operand_b;
            OP_NOT:  alu_result = ~operand_a;
            OP_SHL:  alu_result = operand_a << shift_amount;
            OP_SHR:  alu_result = operand_a >> shift_amount;
            OP_PASS: alu_result = operand_a;
            OP_SLT:  alu_result = {{(DATA_W-1){1'b0}}, (operand_a < operand_b)};
            OP_SEQ:  alu_result = {{(DATA_W-1){1'b0}}, (operand_a == operand_b)};
            default: alu_result = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            out <= '0;
        end else begin
            out <= alu_result;
        end
    end

endmodule

// File: tb/tb_harvard_fetch_alu.sv
// Scoreboard bench for harvard_fetch_alu: one instance runs the bring-up program,
// a second runs an opcode-sweep ROM; a spec-level model predicts every cycle.
module tb_harvard_fetch_alu;

    localparam logic [31:0] MAIN_ROM [64] = '{
        0:       32'h00005003,
        1:       32'h10005003,
        2:       32'h2000C00A,
        3:       32'h30F0F0FF,
        4:       32'h40F0000F,
        5:       32'h50FFF0F0,
        6:       32'h10003005,
        7:       32'h7000101F,
        default: 32'h00000000
    };

    // Corner cases for every opcode, including reserved bits set and shift counts above 31.
    localparam logic [31:0] SWEEP_ROM [64] = '{
        0:       32'h60000000,
        1:       32'h80800003,
        2:       32'h90ABC000,
        3:       32'hA0002003,
        4:       32'hB0007007,
        5:       32'hD0FFFFFF,
        6:       32'h8FFFF023,
        7:       32'hA0005003,
        8:       32'hB0007008,
        9:       32'h2FFFFFFF,
        10:      32'h70FFF01F,
        11:      32'h0FFFFFFF,
        12:      32'h10000FFF,
        13:      32'hF1234567,
        14:      32'hC0001001,
        15:      32'h60FFF000,
        16:      32'h3ABCD5A5,
        17:      32'h4A5A0A5A,
        18:      32'h5CCC0333,
        19:      32'h9FFFF000,
        20:      32'hE0ABCDEF,
        21:      32'h70ABC040,
        22:      32'hA0FFF000,
        23:      32'hB0000000,
        default: 32'h00000000
    };

    typedef struct {
        logic [5:0]  counter;
        logic [31:0] instr;
        logic [31:0] out;
    } exp_t;

    logic        clk;
    logic        reset;
    logic        reset_sweep;
    logic [5:0]  counter;
    logic [31:0] instruction_out;
    logic [31:0] out;
    logic [5:0]  sweep_counter;
    logic [31:0] sweep_instruction;
    logic [31:0] sweep_out;

    exp_t main_q[$];
    exp_t sweep_q[$];
    int   checks = 0;
    int   errors = 0;
    int   main_pc = 0;
    int   sweep_pc = 0;
    logic [31:0] main_acc = 32'h0;
    logic [31:0] sweep_acc = 32'h0;

    harvard_fetch_alu dut (
        .clk             (clk),
        .reset           (reset),
        .counter         (counter),
        .instruction_out (instruction_out),
        .out             (out)
    );

    harvard_fetch_alu #(.PROGRAM(SWEEP_ROM)) dut_sweep (
        .clk             (clk),
        .reset           (reset_sweep),
        .counter         (sweep_counter),
        .instruction_out (sweep_instruction),
        .out             (sweep_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference ALU written straight from the instruction-set rules.
    function automatic logic [31:0] alu_ref(input logic [31:0] word);
        int unsigned a;
        int unsigned b;
        a = int'(word[23:12]);
        b = int'(word[11:0]);
        case (int'(word[31:28]))
            0:  return a + b;
            1:  return a - b;
            2:  return a * b;
            3:  return a & b;
            4:  return a | b;
            5:  return a ^ b;
            6:  return ~a;
            7:  return a << (b % 32);
            8:  return a >> (b % 32);
            9:  return a;
            10: return (a < b) ? 32'd1 : 32'd0;
            11: return (a == b) ? 32'd1 : 32'd0;
            default: return 32'd0;
        endcase
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive one cycle of reset values, then record what each DUT should show after the edge.
    task automatic applyStimulus(input logic rst_main, input logic rst_sweep);
        reset       = rst_main;
        reset_sweep = rst_sweep;
        @(posedge clk);
        if (rst_main) begin
            main_pc  = 0;
            main_acc = 32'h0;
        end else begin
            main_acc = alu_ref(MAIN_ROM[main_pc]);
            main_pc  = (main_pc + 1) % 64;
        end
        if (rst_sweep) begin
            sweep_pc  = 0;
            sweep_acc = 32'h0;
        end else begin
            sweep_acc = alu_ref(SWEEP_ROM[sweep_pc]);
            sweep_pc  = (sweep_pc + 1) % 64;
        end
        main_q.push_back('{counter: 6'(main_pc), instr: MAIN_ROM[main_pc], out: main_acc});
        sweep_q.push_back('{counter: 6'(sweep_pc), instr: SWEEP_ROM[sweep_pc], out: sweep_acc});
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (main_q.size() > 0) begin
                e = main_q.pop_front();
                checkOutput("main_counter", {26'h0, counter}, {26'h0, e.counter});
                checkOutput("main_instruction", instruction_out, e.instr);
                checkOutput("main_out", out, e.out);
            end
            if (sweep_q.size() > 0) begin
                e = sweep_q.pop_front();
                checkOutput("sweep_counter", {26'h0, sweep_counter}, {26'h0, e.counter});
                checkOutput("sweep_instruction", sweep_instruction, e.instr);
                checkOutput("sweep_out", sweep_out, e.out);
            end
        end
    end

    initial begin : stimulus
        int guard;
        reset       = 1'b1;
        reset_sweep = 1'b1;
        $display("[TB] holding reset for two edges");
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);

        $display("[TB] running program through wrap");
        for (int i = 0; i < 70; i++) begin
            applyStimulus(1'b0, 1'b0);
        end

        $display("[TB] mid-program reset at address 5");
        guard = 0;
        while (main_pc != 5 && guard < 100) begin
            applyStimulus(1'b0, 1'b0);
            guard++;
        end
        applyStimulus(1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0);
        end

        $display("[TB] randomized reset pulses");
        for (int i = 0; i < 400; i++) begin
            applyStimulus($urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0);
        end
        reset       = 1'b0;
        reset_sweep = 1'b0;

        guard = 0;
        while ((main_q.size() > 0 || sweep_q.size() > 0) && guard < 5) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk);
        checkOutput("scoreboard_drain", 32'(main_q.size() + sweep_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
